// File: rtl/rns_ohc_pkg.sv
// rns_ohc_pkg
//   Items shared by the RNS one-hot-code blocks:
//     ERR_CNT_W            - width of the saturating error counters
//     OHC_MOD_MIN/MAX      - legal modulus range for one-hot residue blocks
//     err_cnt_t            - error counter type
//     ohc_bin_w(mod)       - binary residue width for a given modulus
package rns_ohc_pkg;

    localparam int unsigned ERR_CNT_W   = 16;
    localparam int unsigned OHC_MOD_MIN = 2;
    localparam int unsigned OHC_MOD_MAX = 64;

    typedef logic [ERR_CNT_W-1:0] err_cnt_t;

    // Residues 0..mod-1 need $clog2(mod) bits; never less than one bit.
    function automatic int unsigned ohc_bin_w(input int unsigned mod);
        return (mod <= 2) ? 1 : $clog2(mod);
    endfunction

endpackage

// File: rtl/ohc_encode.sv
// ohc_encode
//   Combinational one-hot validator and encoder for an RNS residue.
//   Parameters:
//     modulus (MOD), also the one-hot input width (2..64)
//     OUT_W  - binary residue width
//   Ports:
//     ohc_i  [MOD-1:0]   one-hot residue, bit k set encodes residue k
//     bin_o  [OUT_W-1:0] binary residue, 0 whenever err_o is set
//     err_o              input was not exactly one-hot
module ohc_encode
    import rns_ohc_pkg::*;
#(
    parameter int unsigned MOD   = 7,
    parameter int unsigned OUT_W = ohc_bin_w(MOD)
) (
    input  logic [MOD-1:0]   ohc_i,
    output logic [OUT_W-1:0] bin_o,
    output logic             err_o
);

    if ((MOD < OHC_MOD_MIN) || (MOD > OHC_MOD_MAX)) begin : g_bad_mod
        $fatal(1, "ohc_encode: MOD=%0d outside legal range", MOD);
    end

    logic             seen_one;
    logic             seen_many;
    logic [OUT_W-1:0] idx;

    // seen_many latches once a second set bit follows the first, so the
    // scan distinguishes zero / one / several bits without a popcount.
    always_comb begin
        seen_one  = 1'b0;
        seen_many = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < MOD; k++) begin
            if (ohc_i[k]) begin
                seen_many = seen_many | seen_one;
                seen_one  = 1'b1;
                idx       = OUT_W'(k);
            end
        end
        err_o = !seen_one || seen_many;
        bin_o = err_o ? '0 : idx;
    end

endmodule

// File: rtl/ohc_mod_to_binary_pipe.sv
// ohc_mod_to_binary_pipe
//   Two-stage valid/ready pipeline converting a one-hot RNS residue to
//   binary. S1 registers the input word, S2 registers the encoded residue
//   and the not-one-hot error flag.
//   Build option: define OHC_ERR_CNT_EN to include the saturating error
//   counter; otherwise err_cnt is tied to zero and err_clr is ignored.
//   Parameters:
//     modulus (MOD), also the one-hot input width (2..64)
//     OUT_W  - binary residue width (leave at default)
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     in_valid/in_ready    input handshake, in_ohc [MOD-1:0] payload
//     out_valid/out_ready  output handshake
//     out_bin [OUT_W-1:0]  binary residue
//     out_err              input word was not exactly one-hot
//     err_clr              synchronous clear of err_cnt
//     err_cnt [15:0]       saturating count of errored output transfers
module ohc_mod_to_binary_pipe
    import rns_ohc_pkg::*;
#(
    parameter int unsigned MOD   = 7,
    parameter int unsigned OUT_W = ohc_bin_w(MOD)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MOD-1:0]       in_ohc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_bin,
    output logic                 out_err,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    if ((MOD < OHC_MOD_MIN) || (MOD > OHC_MOD_MAX)) begin : g_bad_mod
        $fatal(1, "ohc_mod_to_binary_pipe: MOD=%0d outside legal range", MOD);
    end

    logic             v1_q, v1_d;
    logic [MOD-1:0]   ohc1_q, ohc1_d;
    logic             v2_q, v2_d;
    logic [OUT_W-1:0] bin2_q, bin2_d;
    logic             err2_q, err2_d;

    logic             in_xfer;
    logic             out_xfer;
    logic             s1_adv;
    logic [OUT_W-1:0] enc_bin;
    logic             enc_err;

    ohc_encode #(
        .MOD   (MOD),
        .OUT_W (OUT_W)
    ) u_encode (
        .ohc_i (ohc1_q),
        .bin_o (enc_bin),
        .err_o (enc_err)
    );

    // Ready only falls when both stages are full and the output is stalled,
    // so a full pipe still accepts a word in the cycle it drains one.
    assign in_ready  = !v1_q || !v2_q || out_ready;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = v2_q && out_ready;
    assign s1_adv    = v1_q && (!v2_q || out_ready);

    assign out_valid = v2_q;
    assign out_bin   = bin2_q;
    assign out_err   = err2_q;

    always_comb begin
        v1_d   = v1_q;
        ohc1_d = ohc1_q;
        v2_d   = v2_q;
        bin2_d = bin2_q;
        err2_d = err2_q;

        // A new word overrides the S1 drain in the same cycle.
        if (in_xfer) begin
            v1_d   = 1'b1;
            ohc1_d = in_ohc;
        end else if (s1_adv) begin
            v1_d = 1'b0;
        end

        // S2 payload changes only on advance, which requires out_ready
        // when S2 is occupied, keeping a stalled result stable.
        if (s1_adv) begin
            v2_d   = 1'b1;
            bin2_d = enc_bin;
            err2_d = enc_err;
        end else if (out_xfer) begin
            v2_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            ohc1_q <= '0;
            v2_q   <= 1'b0;
            bin2_q <= '0;
            err2_q <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            ohc1_q <= ohc1_d;
            v2_q   <= v2_d;
            bin2_q <= bin2_d;
            err2_q <= err2_d;
        end
    end

`ifdef OHC_ERR_CNT_EN
    err_cnt_t err_cnt_q, err_cnt_d;
    logic     cnt_evt;

    assign cnt_evt = out_xfer && err2_q;

    // Clear wins over increment but still counts the coincident event.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = cnt_evt ? ERR_CNT_W'(1) : '0;
        end else if (cnt_evt && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign err_cnt        = '0;
`endif

endmodule

// File: doc/ohc_mod_to_binary_pipe.md
OHC_MOD_TO_BINARY_PIPE -- requirements
Module: ohc_mod_to_binary_pipe

Interface
REQ-001 SHALL have parameter MOD, default 7, meaning the RNS modulus and the one-hot input width; legal range 2..64.
REQ-002 SHALL have parameter OUT_W, default $clog2(MOD), meaning the binary residue width; not overridden by the instantiator.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, meaning the input word is offered.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts the input word this cycle.
REQ-007 SHALL have port in_ohc, input, MOD, the one-hot residue; bit k set encodes residue k.
REQ-008 SHALL have port out_valid, output, 1, meaning a result is presented.
REQ-009 SHALL have port out_ready, input, 1, meaning downstream accepts the result.
REQ-010 SHALL have port out_bin, output, OUT_W, the binary residue.
REQ-011 SHALL have port out_err, output, 1, meaning the input word was not exactly one-hot.
REQ-012 SHALL have port err_clr, input, 1, a synchronous clear of the error counter (ERR_CNT build only).
REQ-013 SHALL have port err_cnt, output, 16, the saturating error count (ERR_CNT build only).

Function
REQ-014 SHALL implement a 2-stage pipeline: S1 registers in_ohc; S2 registers the encoded result and error flag.
REQ-015 SHALL transfer the input when in_valid && in_ready, and the output when out_valid && out_ready.
REQ-016 SHALL drive in_ready = !v1 || !v2 || out_ready, where v1 and v2 are the stage-valid flags; in_ready SHALL not depend on in_valid.
REQ-017 SHALL advance S1 into S2 when v1 && (!v2 || out_ready).
REQ-018 SHALL present a result 2 cycles after acceptance when unstalled, and sustain 1 word/cycle throughput with out_ready held high.
REQ-019 SHALL hold out_bin and out_err stable while out_valid && !out_ready, and SHALL drop or duplicate no word under any stall pattern.
REQ-020 SHALL set out_bin = k and out_err = 0 when exactly bit k of the word is set.
REQ-021 SHALL set out_bin = 0 and out_err = 1 when the word has zero bits set or two or more bits set.
REQ-022 SHALL never emit X on out_bin; the default branch of the encoder yields 0.
REQ-023 SHALL, when v2 is emptied by an output transfer and S1 is simultaneously filled, accept the new input and advance S1 into S2 in the same cycle.

Reset
REQ-024 SHALL, while rst_n = 0, force v1 = 0, v2 = 0, out_valid = 0, out_bin = 0, out_err = 0 and err_cnt = 0 asynchronously.
REQ-025 SHALL discard in-flight words on reset mid-operation; the first output after deassertion comes from a post-reset acceptance.
REQ-026 SHALL leave in_ready = 1 in the first cycle after reset deassertion.

Configuration
REQ-027 SHALL use the macro OHC_ERR_CNT_EN to compile the error counter in or out.
REQ-028 With OHC_ERR_CNT_EN defined, err_cnt SHALL increment on each output transfer with out_err = 1, saturate at 16'hFFFF, and clear on err_clr.
REQ-029 With OHC_ERR_CNT_EN defined, err_clr and a counted transfer in the same cycle SHALL leave err_cnt = 1.
REQ-030 With OHC_ERR_CNT_EN undefined, err_cnt SHALL be tied to 0, err_clr SHALL be ignored, and no counter flops SHALL exist.

Structure
REQ-031 SHALL take shared items from package rns_ohc_pkg: the width function ohc_bin_w(MOD), the ERR_CNT_W = 16 constant, and the legal-modulus limits.
REQ-032 SHALL place one-hot validation and encoding in the combinational sub-module ohc_encode (MOD → bin, err), reusable by other RNS blocks.
REQ-033 SHALL fail at elaboration when MOD is outside 2..64.

Verification
REQ-034 MOD=7, out_ready=1: inputs 7'b0000001 to 7'b1000000, one per cycle, SHALL produce out_bin 0 through 6, each 2 cycles after its input, with err=0.
REQ-035 MOD=7: input 7'b0000000 SHALL produce bin=0, err=1; input 7'b0010010 SHALL produce bin=0, err=1; err_cnt SHALL read 2 (ERR_CNT build).
REQ-036 MOD=7: out_ready low for 5 cycles while 3 words stream in SHALL leave in_ready low after 2 acceptances; the output SHALL be held stable; on release, words SHALL arrive in order without loss.
REQ-037 MOD=13: random one-hot words with random out_ready SHALL match the scoreboard; out_bin SHALL be 4 bits and reach 12 for bit 12.
REQ-038 With err_cnt preset to 16'hFFFE, 3 bad words SHALL leave err_cnt at 16'hFFFF; err_clr asserted together with a bad transfer SHALL leave err_cnt = 1.
REQ-039 Asserting rst_n low with 2 words in flight SHALL deassert out_valid immediately; after release, no stale word SHALL appear.
